reverse_sched: RTL
==================

Name: reverse_sched

Overview:
Round-robin scheduler that shares one digit-reversal engine (start/x in, Done/reverse out) among NREQ requesters. It latches the granted requester's operand, then drives the engine's start and x. It waits for the engine's Done, captures the result and returns it with a one-cycle valid pulse to the owning requester. It sits between the client blocks and the single `reverse` instance, and is the only driver of that engine's start and x.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width in bits
TIMEOUT, 255, engine watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request; held high until that requester's rsp_valid bit
x_in  in  NREQ*WIDTH  operands; slice i = x_in[i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot; high for exactly one cycle when an operand is accepted
rsp_valid  out  NREQ  one-hot, one-cycle pulse marking result for requester i
rsp_data  out  WIDTH  result, valid only when any rsp_valid bit is high
busy  out  1  high in every state except IDLE
eng_start  out  1  engine start, one-cycle pulse
eng_x  out  WIDTH  engine operand, held stable from ISSUE through WAIT
eng_done  in  1  engine Done
eng_result  in  WIDTH  engine reverse output, sampled when eng_done is high in WAIT

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt, rsp_valid, eng_start = 0; rsp_data, eng_x = 0; busy = 0; RR pointer = 0; owner = 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if |req, pick the first asserted index at or after the pointer, wrapping modulo NREQ. That cycle: gnt[k]=1, owner<=k, eng_x<=x_in slice k. Next state ISSUE. If req==0, stay in IDLE.
- ISSUE: eng_start=1 for one cycle. Next state WAIT.
- WAIT: when eng_done=1, rsp_data<=eng_result and go to RESP. Otherwise stay.
- RESP: rsp_valid[owner]=1 for one cycle; pointer<=(owner+1) mod NREQ. Next state IDLE.
- Latency: grant to rsp_valid = engine latency (ISSUE to Done) + 3 cycles. Back-to-back transactions need a minimum of 1 IDLE cycle between RESP and the next gnt.
- eng_done is ignored in IDLE, ISSUE and RESP; no action and no error.
- A requester that drops req after gnt still receives its rsp_valid. Its next request only re-arbitrates once the scheduler is back in IDLE.
- Changes to x_in after gnt do not affect the transaction in flight.
- Only one transaction is outstanding at a time. req from other requesters during busy is held pending, with no loss and no grant.
- Fairness: with all requests continuously high, the grant order is 0,1,...,NREQ-1,0,...
- A pointer at NREQ-1 wraps to 0.
- rst asserted mid-transaction aborts it immediately: no rsp_valid and the pointer returns to 0. The engine shares rst, so it restarts cleanly.
- Outputs are registered, except gnt, which may be a combinational decode of the IDLE-state pick.

Optional Feature:
Macro REVERSE_SCHED_TIMEOUT_EN.
- Defined: adds port rsp_err (out, 1) and an 8-bit watchdog cleared on entry to WAIT. If TIMEOUT cycles elapse in WAIT without eng_done, go to RESP with rsp_data=0 and rsp_err=1 alongside rsp_valid[owner]. rsp_err is 0 otherwise, and 0 after reset.
- Not defined: no rsp_err port and no counter. WAIT waits for eng_done indefinitely.

Decomposition:
- Package reverse_pkg holds: the state enum sched_state_t {IDLE, ISSUE, WAIT, RESP}, the default constants for NREQ and WIDTH, and the watchdog width constant.
- Sub-module rr_pick: combinational round-robin first-one finder. Inputs req[NREQ] and ptr; outputs a one-hot grant, the index and any.

Test Plan (NREQ=4, WIDTH=16, engine model: decimal digit reverse, Done 5 cycles after start):
- Single request: req[0]=1, x=123 -> gnt[0] pulse, eng_x=123, one eng_start pulse, rsp_valid[0] with rsp_data=321, 8 cycles after gnt.
- Contention: req=4'b1111 held, operands 10,20,30,40 -> responses in order 0,1,2,3 with data 1,2,3,4; then the pointer wraps and requester 0 is granted again.
- Wrap: pointer at 3 (after serving 2), req=4'b1001 -> requester 3 granted first, then requester 0.
- Drop and operand change: req[1] and x change after gnt, during WAIT -> rsp_valid[1] still pulses with the original operand's result; no extra gnt.
- Reset mid-operation: assert rst during WAIT -> all outputs 0 in the same cycle; after release, a new request is served normally and the stale engine Done is never reported.
- With REVERSE_SCHED_TIMEOUT_EN and TIMEOUT=20: engine never asserts Done -> rsp_valid[owner]=1, rsp_err=1, rsp_data=0 at 20 cycles in WAIT. A following normal request returns rsp_err=0.

Source files
------------

// File: rtl/reverse_pkg.sv
// Shared types and constants for the reverse_sched scheduler and its round-robin picker.
package reverse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 16;
  localparam int WD_W      = 8;

endpackage

// File: rtl/reverse_sched_rr_pick.sv
// Combinational round-robin first-one finder: nearest asserted request at or after ptr, wrapping.
module rr_pick
  import reverse_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Walk from the farthest candidate toward ptr so the nearest hit is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int cand;
      cand = (int'(ptr) + off) % NREQ;
      if (req[cand]) begin
        any       = 1'b1;
        idx       = IDXW'(cand);
        gnt       = '0;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reverse_sched.sv
// Round-robin scheduler sharing one digit-reversal engine among NREQ requesters.
// Define REVERSE_SCHED_TIMEOUT_EN to add the rsp_err port and the TIMEOUT-cycle engine watchdog.
module reverse_sched
  import reverse_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
`ifdef REVERSE_SCHED_TIMEOUT_EN
  output logic                  rsp_err,
`endif
  output logic                  busy,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_x,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_result
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > (1 << WD_W) - 1) begin : g_bad_cfg
    $error("reverse_sched: NREQ must be 2..8 and TIMEOUT 1..255");
  end

  sched_state_t     state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0] eng_x_q, eng_x_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             eng_start_q, eng_start_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_x;
  logic [NREQ-1:0]  owner_hot;
  logic             wd_expired;

`ifdef REVERSE_SCHED_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner_dec
    assign owner_hot[gi] = (owner_q == IDXW'(gi));
  end

  always_comb begin
    pick_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_x = pick_x | x_in[i*WIDTH +: WIDTH];
    end
  end

`ifdef REVERSE_SCHED_TIMEOUT_EN
  assign wd_expired = (state_q == WAIT) && !eng_done && (wd_q == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      eng_x_q     <= '0;
      rsp_data_q  <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
`ifdef REVERSE_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      eng_x_q     <= eng_x_d;
      rsp_data_q  <= rsp_data_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef REVERSE_SCHED_TIMEOUT_EN
      wd_q        <= wd_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    eng_x_d    = eng_x_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          eng_x_d = pick_x;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (eng_done) begin
          rsp_data_d = eng_result;
          state_d    = RESP;
        end else if (wd_expired) begin
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        ptr_d   = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the registered ones are computed one cycle ahead; gnt is the live IDLE pick.
  always_comb begin
    gnt         = (state_q == IDLE && !rst) ? pick_gnt : '0;
    eng_start_d = (state_q == ISSUE);
    rsp_valid_d = (state_q == WAIT && state_d == RESP) ? owner_hot : '0;
    busy_d      = (state_d != IDLE);
`ifdef REVERSE_SCHED_TIMEOUT_EN
    rsp_err_d   = wd_expired;
    wd_d        = wd_q;
    if (state_q == ISSUE)     wd_d = '0;
    else if (state_q == WAIT) wd_d = wd_q + WD_W'(1);
`endif
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_x     = eng_x_q;
`ifdef REVERSE_SCHED_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`endif

endmodule
